// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV32I-subset control path: opcodes, ALU codes, mux selects and FSM states.
package riscv_ctrl_pkg;

    localparam int unsigned OPC_W  = 7;
    localparam int unsigned ALU_W  = 4;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned STATE_W = 3;

    localparam logic [OPC_W-1:0] OP_RTYPE  = 7'b0110011;
    localparam logic [OPC_W-1:0] OP_IALU   = 7'b0010011;
    localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;

    localparam logic [ALU_W-1:0] ALU_AND  = 4'b0000;
    localparam logic [ALU_W-1:0] ALU_OR   = 4'b0001;
    localparam logic [ALU_W-1:0] ALU_ADD  = 4'b0010;
    localparam logic [ALU_W-1:0] ALU_SUB  = 4'b0110;
    localparam logic [ALU_W-1:0] ALU_SRL  = 4'b1000;
    localparam logic [ALU_W-1:0] ALU_NONE = 4'b1111;

    localparam logic [SEL_W-1:0] SRC_A_RS1    = 2'b00;
    localparam logic [SEL_W-1:0] SRC_A_PC     = 2'b01;
    localparam logic [SEL_W-1:0] SRC_A_OLD_PC = 2'b10;

    localparam logic [SEL_W-1:0] SRC_B_RS2  = 2'b00;
    localparam logic [SEL_W-1:0] SRC_B_IMM  = 2'b01;
    localparam logic [SEL_W-1:0] SRC_B_FOUR = 2'b10;

    localparam logic [SEL_W-1:0] WB_SEL_ALU = 2'b00;
    localparam logic [SEL_W-1:0] WB_SEL_MDR = 2'b01;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        TRAP   = 3'd6
    } state_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Control-unit <-> datapath bundle: instruction fields and status in, control strobes and status out.
interface multicycle_control_if #(
    parameter int unsigned CNT_W = 32
);
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic             zero;
    logic             mem_ready;

    logic             pc_write;
    logic             ir_write;
    logic             iord;
    logic             branch;
    logic [1:0]       alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       mem_to_reg;
    logic [3:0]       alu_control;
    logic             regwrite;
    logic             mem_read;
    logic             mem_write;
    logic             illegal_instr;
    logic             bus_error;
    logic [CNT_W-1:0] instret;
    logic [2:0]       state_o;

    modport master (
        input  opcode, funct3, funct7, zero, mem_ready,
        output pc_write, ir_write, iord, branch, alu_src_a, alu_src_b, mem_to_reg,
               alu_control, regwrite, mem_read, mem_write, illegal_instr, bus_error,
               instret, state_o
    );

    modport slave (
        output opcode, funct3, funct7, zero, mem_ready,
        input  pc_write, ir_write, iord, branch, alu_src_a, alu_src_b, mem_to_reg,
               alu_control, regwrite, mem_read, mem_write, illegal_instr, bus_error,
               instret, state_o
    );
endinterface

// File: rtl/riscv_alu_decoder.sv
// Instruction-field decoder: selects the ALU operation and flags whether the encoding is supported.
module riscv_alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] alu_control,
    output logic       legal
);
    always_comb begin
        alu_control = ALU_NONE;
        legal       = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct3)
                    3'b000: begin
                        if (funct7 == 7'b0000000) begin
                            alu_control = ALU_ADD;
                            legal       = 1'b1;
                        end else if (funct7 == 7'b0100000) begin
                            alu_control = ALU_SUB;
                            legal       = 1'b1;
                        end
                    end
                    3'b110: begin alu_control = ALU_OR;  legal = 1'b1; end
                    3'b111: begin alu_control = ALU_AND; legal = 1'b1; end
                    3'b101: begin
                        if (funct7 == 7'b0000000) begin
                            alu_control = ALU_SRL;
                            legal       = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            OP_IALU: begin
                case (funct3)
                    3'b000: begin alu_control = ALU_ADD; legal = 1'b1; end
                    3'b110: begin alu_control = ALU_OR;  legal = 1'b1; end
                    3'b111: begin alu_control = ALU_AND; legal = 1'b1; end
                    3'b101: begin
                        if (funct7 == 7'b0000000) begin
                            alu_control = ALU_SRL;
                            legal       = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            OP_LOAD, OP_STORE: begin
                if (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010) begin
                    alu_control = ALU_ADD;
                    legal       = 1'b1;
                end
            end
            OP_BRANCH: begin
                if (funct3 == 3'b000) begin
                    alu_control = ALU_SUB;
                    legal       = 1'b1;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I-subset main control: Moore FSM over a shared ALU and unified memory,
// with memory-ready handshake, optional access timeout, sticky error flags and retire counter.
module multicycle_control
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 15,
    parameter int unsigned CNT_W          = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.master bus
);
    localparam int unsigned WAIT_W  = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic [CNT_W-1:0]  instret;
    logic              illegal_q, bus_err_q;
    logic              set_illegal_c, set_bus_err_c, retire_c, timeout_c;
    logic [3:0]        dec_alu;
    logic              dec_legal;
    logic              is_load, is_store;

    riscv_alu_decoder u_dec (
        .opcode      (bus.opcode),
        .funct3      (bus.funct3),
        .funct7      (bus.funct7),
        .alu_control (dec_alu),
        .legal       (dec_legal)
    );

    assign is_load   = (bus.opcode == OP_LOAD);
    assign is_store  = (bus.opcode == OP_STORE);
    // Expires on the cycle whose miss would make the wait count reach TIMEOUT_CYCLES.
    assign timeout_c = (TIMEOUT_CYCLES != 0) && !bus.mem_ready && (wait_cnt == WAIT_W'(TO_LAST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            instret   <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (retire_c)      instret   <= instret + CNT_W'(1);
            if (set_illegal_c) illegal_q <= 1'b1;
            if (set_bus_err_c) bus_err_q <= 1'b1;
        end
    end

    always_comb begin
        state_nxt       = state;
        set_illegal_c   = 1'b0;
        set_bus_err_c   = 1'b0;
        bus.pc_write    = 1'b0;
        bus.ir_write    = 1'b0;
        bus.iord        = 1'b0;
        bus.branch      = 1'b0;
        bus.alu_src_a   = SRC_A_RS1;
        bus.alu_src_b   = SRC_B_RS2;
        bus.mem_to_reg  = WB_SEL_ALU;
        bus.alu_control = ALU_NONE;
        bus.regwrite    = 1'b0;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        case (state)
            IDLE: state_nxt = FETCH;
            FETCH: begin
                bus.mem_read    = 1'b1;
                bus.alu_src_a   = SRC_A_PC;
                bus.alu_src_b   = SRC_B_FOUR;
                bus.alu_control = ALU_ADD;
                if (bus.mem_ready) begin
                    bus.ir_write = 1'b1;
                    bus.pc_write = 1'b1;
                    state_nxt    = DECODE;
                end else if (timeout_c) begin
                    state_nxt     = TRAP;
                    set_bus_err_c = 1'b1;
                end
            end
            DECODE: begin
                bus.alu_src_a   = SRC_A_OLD_PC;
                bus.alu_src_b   = SRC_B_IMM;
                bus.alu_control = ALU_ADD;
                if (dec_legal) begin
                    state_nxt = EXEC;
                end else begin
                    state_nxt     = TRAP;
                    set_illegal_c = 1'b1;
                end
            end
            EXEC: begin
                bus.alu_control = dec_alu;
                case (bus.opcode)
                    OP_RTYPE: state_nxt = WB;
                    OP_IALU: begin
                        bus.alu_src_b = SRC_B_IMM;
                        state_nxt     = WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        bus.alu_src_b = SRC_B_IMM;
                        state_nxt     = MEM;
                    end
                    OP_BRANCH: begin
                        bus.branch = 1'b1;
                        state_nxt  = FETCH;
                    end
                    default: begin
                        bus.alu_control = ALU_NONE;
                        state_nxt       = TRAP;
                        set_illegal_c   = 1'b1;
                    end
                endcase
            end
            MEM: begin
                bus.iord      = 1'b1;
                bus.mem_read  = is_load;
                bus.mem_write = is_store;
                if (bus.mem_ready) begin
                    state_nxt = is_store ? FETCH : WB;
                end else if (timeout_c) begin
                    state_nxt     = TRAP;
                    set_bus_err_c = 1'b1;
                end
            end
            WB: begin
                bus.regwrite   = 1'b1;
                bus.mem_to_reg = is_load ? WB_SEL_MDR : WB_SEL_ALU;
                state_nxt      = FETCH;
            end
            TRAP: ;
            default: state_nxt = IDLE;
        endcase

        retire_c = (state_nxt == FETCH) && (state == EXEC || state == MEM || state == WB);

        // Count only while an access is still outstanding; any exit or handshake restarts from zero.
        wait_nxt = '0;
        if ((state == FETCH || state == MEM) && state_nxt == state && !bus.mem_ready)
            wait_nxt = wait_cnt + WAIT_W'(1);
    end

    assign bus.instret       = instret;
    assign bus.illegal_instr = illegal_q;
    assign bus.bus_error     = bus_err_q;
    assign bus.state_o       = 3'(state);

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Parametrised successor to the single-cycle main control unit, for the multi-cycle RV32I subset datapath.
- A Moore-style FSM sequences FETCH, DECODE, EXEC, MEM and WB over a shared ALU and a unified memory.
- Handles variable memory latency with a ready handshake, with an optional timeout.
- Flags illegal instructions and bus errors, and counts retired instructions.

Parameters:
TIMEOUT_CYCLES, 15, maximum wait cycles for mem_ready before a bus error; 0 disables the timeout.
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  7  IR[6:0]; stable from DECODE onward
funct3  in  3  IR[14:12]
funct7  in  7  IR[31:25]
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current access this cycle
pc_write  out  1  unconditional PC load
ir_write  out  1  IR load
iord  out  1  memory address select: 0 = PC, 1 = ALUOut
branch  out  1  conditional PC load (PC loads when branch & zero)
alu_src_a  out  2  00 = rs1, 01 = PC, 10 = old PC
alu_src_b  out  2  00 = rs2, 01 = imm, 10 = constant 4
mem_to_reg  out  2  00 = ALUOut, 01 = MDR
alu_control  out  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1000 SRL, 1111 none
regwrite, mem_read, mem_write  out  1 each  enables
illegal_instr  out  1  sticky: illegal instruction trapped
bus_error  out  1  sticky: memory timeout
instret  out  CNT_W  retired-instruction count
state_o  out  3  current state, for debug

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, instret = 0, both sticky flags = 0.
  - All outputs are 0, except alu_control = 1111.
- State transitions:
  - IDLE -> FETCH on the first clk edge after reset release.
- FETCH:
  - Outputs: mem_read = 1, iord = 0, alu_src_a = 01, alu_src_b = 10, ADD.
  - When mem_ready = 1: ir_write = 1 and pc_write = 1 in that same cycle, then -> DECODE. Otherwise stay in FETCH.
- DECODE:
  - Outputs: alu_src_a = 10, alu_src_b = 01, ADD (branch target into ALUOut).
  - Legal instructions:
    - R-type 0110011: {000/f7=0000000 ADD, 000/0100000 SUB, 110 OR, 111 AND, 101/0000000 SRL}.
    - I-ALU 0010011: funct3 {000, 110, 111} and {101 with funct7=0000000}.
    - Load 0000011 and store 0100011: funct3 {000, 001, 010}.
    - BEQ 1100011: funct3 000.
  - Legal -> EXEC. Anything else -> TRAP with illegal_instr set.
- EXEC, by instruction class:
  - R-type: src 00/00, ALU op per funct, -> WB.
  - I-ALU: src 00/01, ALU op per funct3, -> WB.
  - Load/store: src 00/01, ADD, -> MEM.
  - BEQ: src 00/00, SUB, branch = 1, -> FETCH (retires).
- MEM:
  - iord = 1. Load drives mem_read = 1; store drives mem_write = 1.
  - Wait for mem_ready. Load -> WB. Store -> FETCH (retires).
- WB:
  - regwrite = 1 for exactly one cycle, then -> FETCH (retires).
  - mem_to_reg = 01 for loads, 00 otherwise.
- Retirement: instret increments by 1 on each transition into FETCH from EXEC, MEM or WB. It wraps at 2^CNT_W.
- Wait counter:
  - Clears on entry to FETCH or MEM and on mem_ready.
  - Increments on each FETCH/MEM cycle with mem_ready = 0.
  - Reaching TIMEOUT_CYCLES (when nonzero) -> TRAP with bus_error set; the pending access is dropped.
- TRAP:
  - All enables 0, alu_control = 1111.
  - Absorbing: only reset leaves TRAP.
- mem_ready outside FETCH/MEM is ignored.
- Reset mid-access aborts immediately; no write enable may glitch high after rst_n falls.
- Outputs are combinational from state plus the decoded instruction fields. Only state, the wait counter, instret and the sticky flags are registered.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - Opcode constants.
  - ALU_* codes.
  - SRC_A_*, SRC_B_* and WB_SEL_* codes.
  - The state enum (IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP).
- One combinational sub-module, riscv_alu_decoder: (opcode, funct3, funct7) -> alu_control, legal.
  - It is shared with the single-cycle control unit.
  - DECODE uses its legal output.

Test Plan:
- ADD with mem_ready always 1 -> states FETCH, DECODE, EXEC, WB, FETCH; regwrite high for 1 cycle in WB; alu_control 0010 in EXEC; instret 0 -> 1.
- LH (0000011/001) with mem_ready delayed 3 cycles in MEM -> mem_read and iord held for 4 cycles; WB with mem_to_reg 01; total 8 cycles.
- BEQ with zero = 1 -> EXEC drives branch = 1 and alu_control 0110; returns to FETCH after 3 cycles; regwrite never asserted.
- SH with TIMEOUT_CYCLES = 15 and mem_ready held 0 -> mem_write high for 15 cycles, then TRAP with bus_error = 1 and mem_write = 0; TRAP persists until rst_n pulse, which clears the flag.
- Opcode 1111111 -> DECODE -> TRAP with illegal_instr = 1; SRL with funct7 0100000 also traps.
- rst_n dropped asynchronously mid-MEM of a store -> mem_write falls without a clock; state IDLE, instret 0; first fetch follows one cycle after release.
